// File: rtl/frame_sched.sv
// frame_sched: frame-slot scheduler arbitrating the frame buffer between the CPU and scan-out.
// A period counter marks frame slots. Each slot boundary starts one scan of FRAME_WORDS addresses,
// unless the CPU holds the buffer, in which case the scan waits for the CPU to release it.
// Optional feature: define FRAME_SCHED_OVERRUN_CNT_EN to add an 8-bit saturating overrun counter output.
module frame_sched #(
  parameter int FRAME_PERIOD = 450000,
  parameter int FRAME_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  output logic        scan_valid,
  input  logic        scan_ready,
  output logic [15:0] scan_addr,
  output logic        frame_tick,
  output logic        frame_done,
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  output logic        overrun,
  output logic [7:0]  overrun_cnt
`else
  output logic        overrun
`endif
);

  localparam int CNT_W = $clog2(FRAME_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [15:0]      ADDR_LAST = 16'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_CPU, SCAN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cpu_gnt_q;
  logic             scan_valid_q;
  logic [15:0]      scan_addr_q;
  logic             frame_done_q;

  // Next period count: held at zero while disabled, wraps at the end of the slot.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!enable || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick and overrun are decoded straight from registered state so they land in the boundary cycle.
  assign frame_tick = enable && (cnt_q == CNT_LAST);
  assign overrun    = frame_tick && (state_q != IDLE);

  // Frame sequencing FSM; all handshake outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cpu_gnt_q    <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_addr_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            if (cpu_gnt_q) begin
              // CPU keeps the buffer; the scan is deferred until it lets go.
              state_q <= WAIT_CPU;
            end else begin
              state_q      <= SCAN;
              scan_valid_q <= 1'b1;
              scan_addr_q  <= '0;
              cpu_gnt_q    <= 1'b0;
            end
          end else begin
            cpu_gnt_q <= cpu_req;
          end
        end
        WAIT_CPU: begin
          // Grant drops and scan starts on the same edge, so they never overlap.
          if (!cpu_req) begin
            cpu_gnt_q    <= 1'b0;
            state_q      <= SCAN;
            scan_valid_q <= 1'b1;
            scan_addr_q  <= '0;
          end
        end
        SCAN: begin
          if (scan_ready) begin
            if (scan_addr_q == ADDR_LAST) begin
              state_q      <= DONE;
              scan_valid_q <= 1'b0;
              scan_addr_q  <= '0;
              frame_done_q <= 1'b1;
            end else begin
              scan_addr_q <= scan_addr_q + 16'd1;
            end
          end
        end
        DONE: begin
          // Grant is not reissued here; IDLE resamples cpu_req on the following cycle.
          frame_done_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign scan_valid = scan_valid_q;
  assign scan_addr  = scan_addr_q;
  assign frame_done = frame_done_q;

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Overrun counter: counts overrun pulses, only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else if (overrun) begin
      ovr_cnt_q <= sat_inc8(ovr_cnt_q);
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched: directed bench for frame_sched with FRAME_PERIOD=16, FRAME_WORDS=4.
// Cycle n is the cycle following the n-th rising edge after reset release; with enable held
// high, ticks fall on cycles 15, 31, 47, ...
module tb_frame_sched;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cpu_req;
  logic        cpu_gnt;
  logic        scan_valid;
  logic        scan_ready;
  logic [15:0] scan_addr;
  logic        frame_tick;
  logic        frame_done;
  logic        overrun;
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int checks;
  int errors;
  int cyc;
  int done_seen;
  int ov_seen;
  int overlap;

  frame_sched #(
    .FRAME_PERIOD(16),
    .FRAME_WORDS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cpu_req    (cpu_req),
    .cpu_gnt    (cpu_gnt),
    .scan_valid (scan_valid),
    .scan_ready (scan_ready),
    .scan_addr  (scan_addr),
    .frame_tick (frame_tick),
    .frame_done (frame_done),
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    .overrun    (overrun),
    .overrun_cnt(overrun_cnt)
`else
    .overrun    (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and exclusivity monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (overrun === 1'b1) ov_seen++;
    if ((cpu_gnt === 1'b1) && (scan_valid === 1'b1)) overlap++;
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cpu_req = 1'b0; scan_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (cpu_gnt !== 1'b0 || scan_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b valid=%b done=%b expected 0 0 0", cpu_gnt, scan_valid, frame_done);
    end
    checks++;
    if (scan_addr !== 16'd0 || frame_tick !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d tick=%b ovr=%b expected 0 0 0", scan_addr, frame_tick, overrun);
    end
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_ovrcnt: got %0d expected 0", overrun_cnt);
    end
`endif
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_basic();
    int ticks;
    ticks = 0;
    while (cyc < 15) begin
      if (frame_tick !== 1'b0) ticks++;
      step();
    end
    checks++;
    if (ticks != 0) begin
      errors++;
      $display("FAIL basic_early_tick: got %0d ticks expected 0", ticks);
    end
    checks++;
    if (frame_tick !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_tick15: got tick=%b ovr=%b expected 1 0", frame_tick, overrun);
    end
    for (int a = 0; a < 4; a++) begin
      step();
      checks++;
      if (scan_valid !== 1'b1 || scan_addr !== 16'(a)) begin
        errors++;
        $display("FAIL basic_scan: got valid=%b addr=%0d expected 1 %0d", scan_valid, scan_addr, a);
      end
    end
    step();
    checks++;
    if (frame_done !== 1'b1 || scan_valid !== 1'b0 || scan_addr !== 16'd0) begin
      errors++;
      $display("FAIL basic_done: got done=%b valid=%b addr=%0d expected 1 0 0", frame_done, scan_valid, scan_addr);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got %b expected 0", frame_done);
    end
    goto(30);
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL basic_tick30: got %b expected 0", frame_tick);
    end
    step();
    checks++;
    if (frame_tick !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_tick31: got tick=%b ovr=%b expected 1 0", frame_tick, overrun);
    end
    goto(36);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done2: got %b expected 1", frame_done);
    end
    goto(37);
  endtask

  task automatic test_cpu_wait();
    goto(40);
    cpu_req = 1'b1;
    step();
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL cpu_grant: got %b expected 1", cpu_gnt);
    end
    goto(47);
    checks++;
    if (frame_tick !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL cpu_tick: got tick=%b ovr=%b expected 1 0", frame_tick, overrun);
    end
    step();
    checks++;
    if (cpu_gnt !== 1'b1 || scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_wait: got gnt=%b valid=%b expected 1 0", cpu_gnt, scan_valid);
    end
    goto(52);
    cpu_req = 1'b0;
    checks++;
    if (cpu_gnt !== 1'b1 || scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_hold: got gnt=%b valid=%b expected 1 0", cpu_gnt, scan_valid);
    end
    step();
    checks++;
    if (cpu_gnt !== 1'b0 || scan_valid !== 1'b1 || scan_addr !== 16'd0) begin
      errors++;
      $display("FAIL cpu_handover: got gnt=%b valid=%b addr=%0d expected 0 1 0", cpu_gnt, scan_valid, scan_addr);
    end
    goto(57);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL cpu_done: got %b expected 1", frame_done);
    end
    goto(58);
  endtask

  task automatic test_stall();
    goto(62);
    scan_ready = 1'b0;
    goto(64);
    checks++;
    if (scan_valid !== 1'b1 || scan_addr !== 16'd0) begin
      errors++;
      $display("FAIL stall_start: got valid=%b addr=%0d expected 1 0", scan_valid, scan_addr);
    end
    goto(79);
    checks++;
    if (frame_tick !== 1'b1 || overrun !== 1'b1 || scan_addr !== 16'd0) begin
      errors++;
      $display("FAIL stall_overrun: got tick=%b ovr=%b addr=%0d expected 1 1 0", frame_tick, overrun, scan_addr);
    end
    step();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL stall_ovr_width: got %b expected 0", overrun);
    end
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd1) begin
      errors++;
      $display("FAIL stall_ovrcnt: got %0d expected 1", overrun_cnt);
    end
`endif
    goto(83);
    checks++;
    if (scan_valid !== 1'b1 || scan_addr !== 16'd0) begin
      errors++;
      $display("FAIL stall_hold: got valid=%b addr=%0d expected 1 0", scan_valid, scan_addr);
    end
    goto(84);
    scan_ready = 1'b1;
    goto(87);
    checks++;
    if (scan_addr !== 16'd3) begin
      errors++;
      $display("FAIL stall_resume: got addr=%0d expected 3", scan_addr);
    end
    step();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got %b expected 1", frame_done);
    end
    goto(89);
  endtask

  task automatic test_enable();
    int ticks;
    int d0;
    goto(97);
    checks++;
    if (scan_addr !== 16'd1 || scan_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_mid: got addr=%0d valid=%b expected 1 1", scan_addr, scan_valid);
    end
    enable = 1'b0;
    ticks = 0;
    d0 = done_seen;
    while (cyc < 130) begin
      if (frame_tick !== 1'b0) ticks++;
      step();
    end
    checks++;
    if (done_seen - d0 != 1) begin
      errors++;
      $display("FAIL en_finish: got %0d done pulses expected 1", done_seen - d0);
    end
    checks++;
    if (ticks != 0) begin
      errors++;
      $display("FAIL en_no_tick: got %0d ticks expected 0", ticks);
    end
    enable = 1'b1;
    while (cyc < 145) begin
      if (frame_tick !== 1'b0) ticks++;
      step();
    end
    checks++;
    if (ticks != 0 || frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL en_restart: got early=%0d tick=%b expected 0 1", ticks, frame_tick);
    end
    goto(150);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL en_done: got %b expected 1", frame_done);
    end
  endtask

  task automatic test_abort();
    int d0;
    goto(164);
    checks++;
    if (scan_addr !== 16'd2) begin
      errors++;
      $display("FAIL abort_pre: got addr=%0d expected 2", scan_addr);
    end
    d0 = done_seen;
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_gnt !== 1'b0 || scan_valid !== 1'b0 || scan_addr !== 16'd0 ||
        frame_tick !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: got gnt=%b valid=%b addr=%0d tick=%b done=%b ovr=%b expected all 0",
               cpu_gnt, scan_valid, scan_addr, frame_tick, frame_done, overrun);
    end
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_ovrcnt: got %0d expected 0", overrun_cnt);
    end
`endif
    repeat (2) step();
    reset = 1'b0;
    cyc = 0;
    goto(10);
    checks++;
    if (done_seen != d0 || scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done_pulses=%0d valid=%b expected 0 0", done_seen - d0, scan_valid);
    end
  endtask

  task automatic test_saturate();
    int o0;
    scan_ready = 1'b0;
    goto(15);
    o0 = ov_seen;
    goto(15 + 16 * 300 + 1);
    checks++;
    if (ov_seen - o0 != 300) begin
      errors++;
      $display("FAIL sat_pulses: got %0d expected 300", ov_seen - o0);
    end
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_ovrcnt: got %0d expected 255", overrun_cnt);
    end
`endif
  endtask

  task automatic test_mutex();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL gnt_valid_overlap: got %0d cycles expected 0", overlap);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    done_seen = 0; ov_seen = 0; overlap = 0;
    test_reset();
    test_basic();
    test_cpu_wait();
    test_stall();
    test_enable();
    test_abort();
    test_saturate();
    test_mutex();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
